mc_control_fsm: RTL

Parametrised main control unit for the RV32I multicycle core. It owns the state register, the next-state logic and the Moore-decoded control bus in one block. It adds a memory ready/wait handshake, an external stall, per-access size output, a wait-state timeout and a trap state for illegal encodings. It sits between the instruction register (opcode/funct3) and the datapath muxes and enables, and replaces the bare state-to-control decoder.

---
 rtl/mc_control_fsm.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: RV32I multicycle main control FSM with memory handshake, stall, wait timeout and trap.
//   clk, rst_n (sync, active-low)
//   opcode_i/funct3_i  : instruction register fields
//   mem_ready_i        : memory completes current access this cycle
//   stall_i            : external hold
//   *_o controls       : datapath enables and mux selects
//   mem_size_o         : access size (00 byte, 01 half, 10 word)
//   state_o            : current state (debug)
//   illegal_o, mem_timeout_o : sticky error flags
module mc_control_fsm #(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter int unsigned MAX_WAIT      = 0,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       mem_ready_i,
  input  logic       stall_i,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       iord_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] pc_source_o,
  output logic [2:0] mem_to_reg_o,
  output logic [5:0] pc_write_cond_o,
  output logic [1:0] mem_size_o,
  output logic [4:0] state_o,
  output logic       illegal_o,
  output logic       mem_timeout_o
);
  typedef enum logic [4:0] {
    S_FETCH = 5'd0, S_DECODE = 5'd1, S_MEM_ADDR = 5'd2, S_MEM_READ = 5'd3,
    S_LOAD_WB = 5'd4, S_STORE = 5'd5, S_R_EXEC = 5'd6, S_ALU_WB = 5'd7,
    S_BEQ = 5'd8, S_I_EXEC = 5'd9, S_I_WB = 5'd10, S_JAL = 5'd11, S_JALR = 5'd12,
    S_BNE = 5'd15, S_BLT = 5'd16, S_BGE = 5'd17, S_BLTU = 5'd18, S_BGEU = 5'd19,
    S_AUIPC = 5'd20, S_LUI = 5'd21, S_TRAP = 5'd31
  } state_t;
  typedef struct packed {
    logic       reg_write, alu_src_a, mem_read, mem_write, iord, ir_write, pc_write;
    logic [1:0] alu_op, alu_src_b, pc_source;
    logic [2:0] mem_to_reg;
    logic [5:0] pc_write_cond;
    logic [1:0] mem_size;
  } ctrl_t;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
    OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
    OP_AUIPC = 7'b0010111, OP_LUI = 7'b0110111;
  state_t           state_q, state_d, nxt, dec_state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d, timeout_q, timeout_d;
  ctrl_t            ctrl_q;
  logic             mem_st, done, timeout, wen, fetch_gate;
  function automatic ctrl_t decode(state_t s, logic [2:0] f3);
    ctrl_t c;
    c = '0;
    c.mem_size = 2'b10;
    case (s)
      S_FETCH:    begin c.mem_read = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE:   c.alu_src_b = 2'b10;
      S_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEM_READ: begin c.iord = 1'b1; c.mem_read = 1'b1; c.mem_size = f3[1:0]; end
      S_LOAD_WB:  begin c.reg_write = 1'b1; c.mem_to_reg = 3'b001; end
      S_STORE:    begin c.iord = 1'b1; c.mem_write = 1'b1; c.mem_size = f3[1:0]; end
      S_R_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_I_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; c.alu_src_b = 2'b10; end
      S_ALU_WB, S_I_WB: c.reg_write = 1'b1;
      S_BEQ, S_BNE, S_BLT, S_BGE, S_BLTU, S_BGEU: begin
        c.alu_src_a = 1'b1;
        c.alu_op = 2'b01;
        c.pc_source = 2'b10;
        c.pc_write_cond = {s == S_BGEU, s == S_BLTU, s == S_BGE, s == S_BLT, s == S_BNE, s == S_BEQ};
      end
      S_JAL:   begin c.pc_write = 1'b1; c.pc_source = 2'b10; c.reg_write = 1'b1; c.mem_to_reg = 3'b011; end
      S_JALR:  begin c.pc_write = 1'b1; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.reg_write = 1'b1; c.mem_to_reg = 3'b011; end
      S_AUIPC: begin c.reg_write = 1'b1; c.mem_to_reg = 3'b100; end
      S_LUI:   begin c.reg_write = 1'b1; c.mem_to_reg = 3'b010; end
      S_TRAP:  c.mem_size = 2'b00;
      default: ;
    endcase
    return c;
  endfunction
  assign mem_st  = state_q == S_FETCH || state_q == S_MEM_READ || state_q == S_STORE;
  assign done    = !MEM_HANDSHAKE || mem_ready_i;
  assign timeout = MAX_WAIT != 0 && mem_st && !done && cnt_q == CNT_W'(MAX_WAIT);
  always_comb begin
    dec_state = S_TRAP;
    case (opcode_i)
      OP_LOAD:  dec_state = (funct3_i == 3'b011 || funct3_i[2:1] == 2'b11) ? S_TRAP : S_MEM_ADDR;
      OP_STORE: dec_state = (funct3_i[2] || funct3_i == 3'b011) ? S_TRAP : S_MEM_ADDR;
      OP_R:     dec_state = S_R_EXEC;
      OP_I:     dec_state = S_I_EXEC;
      OP_BR:    dec_state = funct3_i == 3'b000 ? S_BEQ : funct3_i == 3'b001 ? S_BNE :
                            funct3_i == 3'b100 ? S_BLT : funct3_i == 3'b101 ? S_BGE :
                            funct3_i == 3'b110 ? S_BLTU : funct3_i == 3'b111 ? S_BGEU : S_TRAP;
      OP_JAL:   dec_state = S_JAL;
      OP_JALR:  dec_state = S_JALR;
      OP_AUIPC: dec_state = S_AUIPC;
      OP_LUI:   dec_state = S_LUI;
      default:  dec_state = S_TRAP;
    endcase
  end
  always_comb begin
    nxt = state_q;
    case (state_q)
      S_FETCH:    nxt = done ? S_DECODE : timeout ? S_TRAP : S_FETCH;
      S_DECODE:   nxt = dec_state;
      S_MEM_ADDR: nxt = opcode_i == OP_LOAD ? S_MEM_READ : opcode_i == OP_STORE ? S_STORE : S_TRAP;
      S_MEM_READ: nxt = done ? S_LOAD_WB : timeout ? S_TRAP : S_MEM_READ;
      S_STORE:    nxt = done ? S_FETCH : timeout ? S_TRAP : S_STORE;
      S_R_EXEC:   nxt = S_ALU_WB;
      S_I_EXEC:   nxt = S_I_WB;
      S_TRAP:     nxt = S_TRAP;
      default:    nxt = S_FETCH;
    endcase
    state_d   = stall_i ? state_q : nxt;
    // counter only advances while a memory state is actually waiting; any state change clears it
    cnt_d     = stall_i ? cnt_q : nxt != state_q ? '0 :
                (mem_st && !done && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    illegal_d = illegal_q || (!stall_i && (state_q == S_DECODE || state_q == S_MEM_ADDR) && nxt == S_TRAP);
    timeout_d = timeout_q || (!stall_i && timeout);
  end
  // control bus is registered from the next state, so ctrl_q always matches decode(state_q)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      ctrl_q    <= decode(S_FETCH, funct3_i);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      ctrl_q    <= decode(state_d, funct3_i);
    end
  end
  assign wen             = rst_n && !stall_i;
  assign fetch_gate      = state_q != S_FETCH || done;
  assign reg_write_o     = ctrl_q.reg_write && wen;
  assign mem_write_o     = ctrl_q.mem_write && wen;
  assign pc_write_o      = ctrl_q.pc_write && wen && fetch_gate;
  assign ir_write_o      = ctrl_q.ir_write && wen && fetch_gate;
  assign pc_write_cond_o = wen ? ctrl_q.pc_write_cond : 6'b0;
  assign alu_src_a_o     = ctrl_q.alu_src_a;
  assign mem_read_o      = ctrl_q.mem_read;
  assign iord_o          = ctrl_q.iord;
  assign alu_op_o        = ctrl_q.alu_op;
  assign alu_src_b_o     = ctrl_q.alu_src_b;
  assign pc_source_o     = ctrl_q.pc_source;
  assign mem_to_reg_o    = ctrl_q.mem_to_reg;
  assign mem_size_o      = ctrl_q.mem_size;
  assign state_o         = state_q;
  assign illegal_o       = illegal_q;
  assign mem_timeout_o   = timeout_q;
endmodule
